// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and helpers for the 2x2 pooling window former
package pool_pkg;

  localparam int DATA_W_DEF = 32;

  // Window slot order; index into the window register array drives data_1..data_4.
  typedef enum logic [1:0] {
    WIN_TL = 2'd0,
    WIN_TR = 2'd1,
    WIN_BL = 2'd2,
    WIN_BR = 2'd3
  } win_pos_e;

  // Phase decoded from row/column parity; there is no state beyond the counters.
  typedef enum logic [1:0] {
    EVEN_ROW     = 2'd0,
    ODD_ROW_LEFT = 2'd1,
    ODD_ROW_EMIT = 2'd2
  } phase_e;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_window_buffer_if.sv
// rtl/pool_window_buffer_if.sv - pixel stream in, 2x2 window out
interface pool_window_buffer_if #(
  parameter int DATA_W = pool_pkg::DATA_W_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
);
  import pool_pkg::*;

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              win_valid;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;
  logic [DATA_W-1:0] data_3;
  logic [DATA_W-1:0] data_4;
  logic              frame_done;
  logic [COL_W-1:0]  col_idx;
  logic [ROW_W-1:0]  row_idx;

  modport master (
    output in_valid, in_data,
    input  win_valid, data_1, data_2, data_3, data_4, frame_done, col_idx, row_idx
  );

  modport slave (
    input  in_valid, in_data,
    output win_valid, data_1, data_2, data_3, data_4, frame_done, col_idx, row_idx
  );

endinterface

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - one-row register file, one write port, two combinational reads
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 8,
  parameter int AW     = cnt_w(IMG_W)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  // Contents are never reset; every even row rewrites all entries before use.
  logic [DATA_W-1:0] mem [IMG_W];

  // Store the even-row pixel at its column.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_buffer.sv
// rtl/pool_window_buffer.sv - stride-2 2x2 window former feeding maxpoolmodule
module pool_window_buffer
  import pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic               Clock,
  input  logic               Reset_n,
  pool_window_buffer_if.slave bus
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] win_q [4];
  logic              win_valid_q;
  logic              frame_done_q;

  phase_e            phase;
  logic              col_last;
  logic              row_last;
  logic [DATA_W-1:0] top_left;
  logic [DATA_W-1:0] top_right;

  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));

  // Phase is purely the row/column parity of the next expected pixel.
  always_comb begin
    phase = EVEN_ROW;
    if (row_q[0]) begin
      phase = col_q[0] ? ODD_ROW_EMIT : ODD_ROW_LEFT;
    end
  end

  // In the emit phase col is odd, so col-1 is the left column of the pair.
  pool_line_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .AW     (COL_W)
  ) u_line_buf (
    .clk       (Clock),
    .wr_en     (bus.in_valid && (phase == EVEN_ROW)),
    .wr_addr   (col_q),
    .wr_data   (bus.in_data),
    .rd_addr_a (col_q - COL_W'(1)),
    .rd_addr_b (col_q),
    .rd_data_a (top_left),
    .rd_data_b (top_right)
  );

  // Raster position counters; a frame wraps straight into the next one.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (bus.in_valid) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Hold the bottom-left pixel until its right-hand partner arrives.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      left_q <= '0;
    end else if (bus.in_valid && (phase == ODD_ROW_LEFT)) begin
      left_q <= bus.in_data;
    end
  end

  // Register a complete window on the bottom-right pixel; strobes last one cycle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      win_q[WIN_TL] <= '0;
      win_q[WIN_TR] <= '0;
      win_q[WIN_BL] <= '0;
      win_q[WIN_BR] <= '0;
      win_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.in_valid && (phase == ODD_ROW_EMIT)) begin
        win_q[WIN_TL] <= top_left;
        win_q[WIN_TR] <= top_right;
        win_q[WIN_BL] <= left_q;
        win_q[WIN_BR] <= bus.in_data;
        win_valid_q   <= 1'b1;
        frame_done_q  <= row_last && col_last;
      end
    end
  end

  assign bus.data_1     = win_q[WIN_TL];
  assign bus.data_2     = win_q[WIN_TR];
  assign bus.data_3     = win_q[WIN_BL];
  assign bus.data_4     = win_q[WIN_BR];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.col_idx    = col_q;
  assign bus.row_idx    = row_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// tb/tb_pool_window_buffer.sv - directed table-driven bench for pool_window_buffer
module tb_pool_window_buffer;
  import pool_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pool_window_buffer_if #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) a_if ();
  pool_window_buffer_if #(.DATA_W(32), .IMG_W(8), .IMG_H(8)) b_if ();
  pool_window_buffer_if #(.DATA_W(32), .IMG_W(2), .IMG_H(2)) c_if ();

  pool_window_buffer #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) dut_a (
    .Clock(clk), .Reset_n(rst_n), .bus(a_if));
  pool_window_buffer #(.DATA_W(32), .IMG_W(8), .IMG_H(8)) dut_b (
    .Clock(clk), .Reset_n(rst_n), .bus(b_if));
  pool_window_buffer #(.DATA_W(32), .IMG_W(2), .IMG_H(2)) dut_c (
    .Clock(clk), .Reset_n(rst_n), .bus(c_if));

  typedef struct {
    logic [31:0] d1, d2, d3, d4;
    logic        fd;
    int          cyc;
  } win_t;

  typedef struct {
    logic [31:0] d1, d2, d3, d4;
    logic        fd;
    int          px;
  } vec_t;

  win_t qa[$];
  win_t qb[$];
  win_t qc[$];
  win_t wa, wb, wc;
  vec_t tab[4];
  int   acc[1:32];
  logic [31:0] pix_b[64];
  bit   stab_en = 1'b0;
  int   stab_err = 0;

  // Window capture on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (a_if.win_valid) begin
      wa = '{a_if.data_1, a_if.data_2, a_if.data_3, a_if.data_4, a_if.frame_done, cyc};
      qa.push_back(wa);
    end
    if (b_if.win_valid) begin
      wb = '{b_if.data_1, b_if.data_2, b_if.data_3, b_if.data_4, b_if.frame_done, cyc};
      qb.push_back(wb);
    end
    if (c_if.win_valid) begin
      wc = '{c_if.data_1, c_if.data_2, c_if.data_3, c_if.data_4, c_if.frame_done, cyc};
      qc.push_back(wc);
    end
  end

  // Between pulses the window must hold and frame_done must stay low.
  always @(negedge clk) begin
    if (stab_en && !a_if.win_valid && qa.size() > 0) begin
      if ({a_if.data_1, a_if.data_2, a_if.data_3, a_if.data_4} !==
          {qa[$].d1, qa[$].d2, qa[$].d3, qa[$].d4} || a_if.frame_done !== 1'b0)
        stab_err++;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [31:0] v, input int gap, input int idx);
    a_if.in_valid = 1'b1;
    a_if.in_data  = v;
    acc[idx]      = cyc + 1;
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
    idle(gap);
  endtask

  task automatic send_b(input logic [31:0] v);
    b_if.in_valid = 1'b1;
    b_if.in_data  = v;
    @(posedge clk);
    #1;
    b_if.in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [31:0] v);
    c_if.in_valid = 1'b1;
    c_if.in_data  = v;
    @(posedge clk);
    #1;
    c_if.in_valid = 1'b0;
  endtask

  task automatic check_frame_a(input int base, input logic [31:0] off, input int px_off,
                               input string tag);
    if (qa.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s win%0d data", tag, i),
            {qa[base+i].d1, qa[base+i].d2, qa[base+i].d3, qa[base+i].d4},
            {tab[i].d1 + off, tab[i].d2 + off, tab[i].d3 + off, tab[i].d4 + off});
        chk($sformatf("%s win%0d frame_done", tag, i), 128'(qa[base+i].fd), 128'(tab[i].fd));
        chk($sformatf("%s win%0d latency", tag, i), 128'(qa[base+i].cyc),
            128'(acc[tab[i].px + px_off]));
      end
    end
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, " win_valid"}, 128'(a_if.win_valid), 128'(0));
    chk({tag, " frame_done"}, 128'(a_if.frame_done), 128'(0));
    chk({tag, " data"}, {a_if.data_1, a_if.data_2, a_if.data_3, a_if.data_4}, 128'(0));
    chk({tag, " col_idx"}, 128'(a_if.col_idx), 128'(0));
    chk({tag, " row_idx"}, 128'(a_if.row_idx), 128'(0));
  endtask

  initial begin
    tab[0] = '{32'd1,  32'd2,  32'd5,  32'd6,  1'b0, 6};
    tab[1] = '{32'd3,  32'd4,  32'd7,  32'd8,  1'b0, 8};
    tab[2] = '{32'd9,  32'd10, 32'd13, 32'd14, 1'b0, 14};
    tab[3] = '{32'd11, 32'd12, 32'd15, 32'd16, 1'b1, 16};

    a_if.in_valid = 1'b0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0;
    c_if.in_valid = 1'b0; c_if.in_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_a_zero("reset");
    chk("reset c win_valid", 128'(c_if.win_valid), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // 4x4 continuous frame
    qa.delete();
    for (int k = 1; k <= 16; k++) send_a(32'(k), 0, k);
    idle(4);
    chk("s1 window count", 128'(qa.size()), 128'(4));
    check_frame_a(0, 0, 0, "s1");
    chk("s1 col_idx end", 128'(a_if.col_idx), 128'(0));
    chk("s1 row_idx end", 128'(a_if.row_idx), 128'(0));

    // Same frame with 3-cycle gaps
    qa.delete();
    stab_en = 1'b1;
    for (int k = 1; k <= 16; k++) send_a(32'(k), 3, k);
    idle(4);
    stab_en = 1'b0;
    chk("s2 window count", 128'(qa.size()), 128'(4));
    check_frame_a(0, 0, 0, "s2");
    chk("s2 hold between pulses", 128'(stab_err), 128'(0));

    // Two frames back to back
    qa.delete();
    for (int k = 1; k <= 16; k++) send_a(32'(k), 0, k);
    for (int k = 1; k <= 16; k++) send_a(32'(100 + k), 0, 16 + k);
    idle(4);
    chk("s3 window count", 128'(qa.size()), 128'(8));
    check_frame_a(0, 0, 0, "s3f1");
    check_frame_a(4, 100, 16, "s3f2");
    if (qa.size() == 8)
      chk("s3 frame_done spacing", 128'(qa[7].cyc - qa[3].cyc), 128'(16));

    // Reset after pixel 7, then a clean frame
    qa.delete();
    for (int k = 1; k <= 7; k++) send_a(32'(k), 0, k);
    rst_n = 1'b0;
    @(negedge clk);
    chk_a_zero("s4 in reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    qa.delete();
    for (int k = 1; k <= 16; k++) send_a(32'(k), 0, k);
    idle(4);
    chk("s4 window count", 128'(qa.size()), 128'(4));
    check_frame_a(0, 0, 0, "s4");

    // 8x8 random frame against a scoreboard
    qb.delete();
    for (int i = 0; i < 64; i++) pix_b[i] = $urandom;
    for (int i = 0; i < 64; i++) send_b(pix_b[i]);
    idle(4);
    chk("s5 window count", 128'(qb.size()), 128'(16));
    if (qb.size() == 16) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("s5 win r%0d c%0d", r, c),
              {qb[r*4+c].d1, qb[r*4+c].d2, qb[r*4+c].d3, qb[r*4+c].d4, 3'b000, qb[r*4+c].fd},
              {pix_b[(2*r)*8 + 2*c], pix_b[(2*r)*8 + 2*c + 1],
               pix_b[(2*r+1)*8 + 2*c], pix_b[(2*r+1)*8 + 2*c + 1],
               3'b000, (r == 3 && c == 3) ? 1'b1 : 1'b0});
        end
      end
    end
    chk("s5 col_idx end", 128'(b_if.col_idx), 128'(0));
    chk("s5 row_idx end", 128'(b_if.row_idx), 128'(0));

    // 2x2 image: a single window that also ends the frame
    qc.delete();
    send_c(32'd7);
    send_c(32'd8);
    send_c(32'd9);
    send_c(32'd10);
    idle(3);
    chk("s6 window count", 128'(qc.size()), 128'(1));
    if (qc.size() == 1) begin
      chk("s6 window data", {qc[0].d1, qc[0].d2, qc[0].d3, qc[0].d4},
          {32'd7, 32'd8, 32'd9, 32'd10});
      chk("s6 frame_done", 128'(qc[0].fd), 128'(1));
    end
    chk("s6 col_idx end", 128'(c_if.col_idx), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool_window_buffer.md
# pool_window_buffer

Streaming 2x2 window former that sits directly upstream of `maxpoolmodule`. It accepts a raster-scan (row-major) feature map one pixel per accepted cycle. It buffers one even row and emits each non-overlapping stride-2 2x2 window as four parallel words that drive `maxpoolmodule`'s `data_1..data_4` directly. A `win_valid` strobe marks cycles on which the window is new.

## Interface
- `DATA_W`, 32: pixel width in bits.
- `IMG_W`, 8: pixels per row; even, ≥ 2.
- `IMG_H`, 8: rows per frame; even, ≥ 2.

Ports:
- `Clock`  in  1  rising-edge clock; single clock domain.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid this cycle; there is no backpressure, so every valid pixel is accepted.
- `in_data`  in  `DATA_W`  pixel, raster order.
- `win_valid`  out  1  one-cycle pulse: `data_1..data_4` hold a new window.
- `data_1`  out  `DATA_W`  pixel (2r, 2c), top-left.
- `data_2`  out  `DATA_W`  pixel (2r, 2c+1), top-right.
- `data_3`  out  `DATA_W`  pixel (2r+1, 2c), bottom-left.
- `data_4`  out  `DATA_W`  pixel (2r+1, 2c+1), bottom-right.
- `frame_done`  out  1  pulses together with the last window of a frame.
- `col_idx`, `row_idx`  out  `$clog2(IMG_W)` and `$clog2(IMG_H)`  position of the next expected pixel; used for debug and bench.

## Operation
- **Counters.** `col` runs 0..`IMG_W`-1 and `row` runs 0..`IMG_H`-1.
  - Both advance only on `in_valid`.
  - `col` wraps to 0 at `IMG_W`-1 and increments `row`.
  - `row` wraps to 0 at `IMG_H`-1; the next pixel starts a new frame with no gap required.
- **Even row** (`row[0]`=0): write `in_data` to `line_buf[col]`.
- **Odd row, even col:** capture `in_data` into the `left` register.
- **Odd row, odd col:** on that accepting edge, register:
  - `data_1` = `line_buf[col-1]`
  - `data_2` = `line_buf[col]`
  - `data_3` = `left`
  - `data_4` = `in_data`
  - set `win_valid`=1.
  - Also set `frame_done`=1 if `row`=`IMG_H`-1 and `col`=`IMG_W`-1.
- **All other cycles:** `win_valid`=0 and `frame_done`=0; `data_1..4` hold their last window.
- **Line buffer.** An even row fully overwrites `line_buf`. Reads during the odd row see only that row's data, so no bypass is needed.
- **Throughput.** `IMG_W`/2 windows per odd row and (`IMG_W`/2)·(`IMG_H`/2) windows per frame.
- **Width.** Pixels pass through unmodified. No arithmetic is performed on data.
- **Reset.** Asserting `Reset_n` low, including mid-frame:
  - clears `col`, `row`, `left`, `data_1..4`, `win_valid`, `frame_done` to 0 asynchronously;
  - leaves `line_buf` contents undefined and unused;
  - the first valid pixel after release is pixel (0,0).
- **No states beyond the counters.** The row-parity/column-parity pair is the phase: EVEN_ROW, ODD_ROW_LEFT, ODD_ROW_EMIT.

## Timing
- Latency: `win_valid` and the window are visible in the cycle after the edge that accepts the bottom-right pixel (one register stage).
- `in_valid` gaps of any length are allowed. The outputs and counters hold, and window content is unaffected.
- Back-to-back frames: the last window of frame N and pixel (0,0) of frame N+1 may be on consecutive cycles.
- Reset values of all outputs: 0.
- Downstream `maxpoolmodule` samples `data_1..4` every `Clock`. It qualifies the result with `win_valid` delayed by its own latency.

## Structure
- Shared package `pool_pkg`:
  - `DATA_W` default;
  - a window-position enum TL/TR/BL/BR mapping to `data_1..4`;
  - counter-width helper via `$clog2`.
- One sub-module, `pool_line_buffer`: `IMG_W`×`DATA_W` register file with one write port and two combinational read ports (`col-1`, `col`).
- Counters, `left` register and output registers live in `pool_window_buffer`.

## Test plan
- **4x4 frame** (`IMG_W`=`IMG_H`=4), values 1..16 streamed continuously. Required windows: (1,2,5,6), (3,4,7,8), (9,10,13,14), (11,12,15,16). `win_valid` is high one cycle after pixels 6, 8, 14, 16. `frame_done` is high only with (11,12,15,16).
- **Same frame with gaps:** `in_valid` low for 3 cycles after every pixel. Required: identical windows; exactly 4 `win_valid` pulses; outputs stable between pulses.
- **Two frames back-to-back:** 1..16 then 101..116. Required: the second frame's windows are (101,102,105,106) … (111,112,115,116). Two `frame_done` pulses, 16 cycles apart.
- **Reset mid-frame:** assert `Reset_n` after pixel 7. Required: all outputs read 0 during reset. After release, a full 1..16 frame yields the four windows of the first scenario.
- **Default 8x8 frame** with random data. Required: a scoreboard matches all 16 windows; `col_idx` and `row_idx` read 0 after the last pixel.
- **`IMG_W`=2, `IMG_H`=2 corner case:** pixels 7,8,9,10. Required: a single window (7,8,9,10) with `win_valid` and `frame_done` high together.
